// File: rtl/rescale_stream_if.sv
// Stream bundle for rescale_stream.
//   up_*  : accumulator beats into the rescaler (LANES x NUM_WIDTH, valid/ready)
//   dn_*  : rescaled pixel beats out (LANES x IMG_WIDTH, per-lane clamp flags, valid/ready)
// The rescaler connects through the slave modport; the producer/consumer side
// around it uses the master modport.
interface rescale_stream_if #(
    parameter int LANES     = 4,
    parameter int NUM_WIDTH = 33,
    parameter int IMG_WIDTH = 16
);
    logic [LANES*NUM_WIDTH-1:0] up_data;
    logic                       up_valid;
    logic                       up_ready;
    logic [LANES*IMG_WIDTH-1:0] dn_data;
    logic [LANES-1:0]           dn_sat;
    logic                       dn_valid;
    logic                       dn_ready;

    modport slave (
        input  up_data, up_valid, dn_ready,
        output up_ready, dn_data, dn_sat, dn_valid
    );

    modport master (
        output up_data, up_valid, dn_ready,
        input  up_ready, dn_data, dn_sat, dn_valid
    );
endinterface

// File: rtl/rescale_stream.sv
// Multi-lane rescaler: each lane of an accepted beat is arithmetically
// right-shifted by the beat's own shift amount (optionally rounded half-up)
// and then saturated to a signed IMG_WIDTH pixel.
//   clk, rst   : clock, asynchronous active-high reset
//   shift      : right-shift amount, travels with the accepted beat
//   round_en   : 1 = round half up, 0 = truncate; travels with the beat
//   sat_clear  : synchronous clear of sat_count (wins over an increment)
//   sat_count  : saturating count of delivered beats with any lane clamped
//   bus        : up_* input stream, dn_* output stream (slave modport)
// Three registered stages: S1 capture, S2 round+shift, S3 clamp/output.
module rescale_stream #(
    parameter int LANES     = 4,
    parameter int NUM_WIDTH = 33,
    parameter int IMG_WIDTH = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           shift,
    input  logic                 round_en,
    input  logic                 sat_clear,
    output logic [CNT_WIDTH-1:0] sat_count,
    rescale_stream_if.slave      bus
);
    localparam int SHW       = $clog2(NUM_WIDTH);
    localparam int MAX_SHIFT = NUM_WIDTH - 1;
    localparam int AW        = NUM_WIDTH + 1;

    typedef logic signed [AW-1:0] wide_t;

    localparam wide_t ONE    = wide_t'(1);
    localparam wide_t SAT_HI = {{(AW-IMG_WIDTH+1){1'b0}}, {(IMG_WIDTH-1){1'b1}}};
    localparam wide_t SAT_LO = ~SAT_HI;
    localparam logic [IMG_WIDTH-1:0] IMG_MAX = {1'b0, {(IMG_WIDTH-1){1'b1}}};
    localparam logic [IMG_WIDTH-1:0] IMG_MIN = {1'b1, {(IMG_WIDTH-1){1'b0}}};

    // Round-half-up then arithmetic shift, one extra bit of headroom so the
    // rounding bias can never wrap the accumulator.
    function automatic wide_t shift_round(input logic [NUM_WIDTH-1:0] x,
                                          input logic [SHW-1:0]       s,
                                          input logic                 rnd);
        wide_t t;
        t = wide_t'(signed'(x));
        if (rnd && (s != '0)) begin
            t = t + (ONE << (s - SHW'(1)));
        end
        return t >>> s;
    endfunction

    // Handshake: each stage may move when it is empty or the next one moves.
    logic adv1, adv2, adv3, accept;

    logic                       v1_q;
    logic [LANES*NUM_WIDTH-1:0] x1_q;
    logic [SHW-1:0]             s1_q;
    logic                       rnd1_q;
    logic [SHW-1:0]             s_eff;

    logic  v2_q;
    wide_t r2_q [LANES];
    wide_t r2_d [LANES];

    logic                       dn_valid_q;
    logic [LANES*IMG_WIDTH-1:0] dn_data_q, dn_data_d;
    logic [LANES-1:0]           dn_sat_q, dn_sat_d;

    logic [CNT_WIDTH-1:0] sat_count_q, sat_count_d;

    assign adv3   = ~dn_valid_q | bus.dn_ready;
    assign adv2   = ~v2_q | adv3;
    assign adv1   = ~v1_q | adv2;
    assign accept = bus.up_valid & adv1;

    // Shifts past NUM_WIDTH-1 behave like NUM_WIDTH-1 (pure sign fill).
    // NOTE: every always_comb output gets a default before any condition, so no latch is inferred.
    always_comb begin
        s_eff = SHW'(shift);
        if (int'(shift) > MAX_SHIFT) begin
            s_eff = SHW'(MAX_SHIFT);
        end
    end

    // ---------------- S1: capture beat and its configuration ----------------
    // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
        end else if (adv1) begin
            v1_q <= bus.up_valid;
        end
    end

    // NOTE: payload registers are qualified by their stage valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            x1_q   <= bus.up_data;
            s1_q   <= s_eff;
            rnd1_q <= round_en;
        end
    end

    // ---------------- S2: round and shift every lane ----------------
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            r2_d[k] = shift_round(x1_q[k*NUM_WIDTH +: NUM_WIDTH], s1_q, rnd1_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q <= 1'b0;
        end else if (adv2) begin
            v2_q <= v1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (adv2 && v1_q) begin
            r2_q <= r2_d;
        end
    end

    // ---------------- S3: clamp to pixel range and hold output ----------------
    always_comb begin
        dn_data_d = '0;
        dn_sat_d  = '0;
        for (int k = 0; k < LANES; k++) begin
            dn_data_d[k*IMG_WIDTH +: IMG_WIDTH] = r2_q[k][IMG_WIDTH-1:0];
            if (r2_q[k] > SAT_HI) begin
                dn_data_d[k*IMG_WIDTH +: IMG_WIDTH] = IMG_MAX;
                dn_sat_d[k] = 1'b1;
            end else if (r2_q[k] < SAT_LO) begin
                dn_data_d[k*IMG_WIDTH +: IMG_WIDTH] = IMG_MIN;
                dn_sat_d[k] = 1'b1;
            end
        end
    end

    // Data only loads with a real beat, so it stays frozen while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dn_valid_q <= 1'b0;
            dn_data_q  <= '0;
            dn_sat_q   <= '0;
        end else if (adv3) begin
            dn_valid_q <= v2_q;
            if (v2_q) begin
                dn_data_q <= dn_data_d;
                dn_sat_q  <= dn_sat_d;
            end
        end
    end

    // ---------------- saturation event counter ----------------
    always_comb begin
        sat_count_d = sat_count_q;
        if (sat_clear) begin
            sat_count_d = '0;
        end else if (dn_valid_q && bus.dn_ready && (|dn_sat_q) && (sat_count_q != '1)) begin
            sat_count_d = sat_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count_q <= '0;
        end else begin
            sat_count_q <= sat_count_d;
        end
    end

    assign bus.up_ready = adv1;
    assign bus.dn_valid = dn_valid_q;
    assign bus.dn_data  = dn_data_q;
    assign bus.dn_sat   = dn_sat_q;
    assign sat_count    = sat_count_q;
endmodule

// File: tb/tb_rescale_stream.sv
// Self-checking bench for rescale_stream: a longint reference model predicts
// every delivered beat and the saturation counter; a negedge monitor compares.
module tb_rescale_stream;
    localparam int LANES = 4;
    localparam int NW    = 33;
    localparam int IW    = 16;
    localparam int CW    = 16;
    localparam longint CMAX = (longint'(1) << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    shift;
    logic          round_en;
    logic          sat_clear;
    logic [CW-1:0] sat_count;

    rescale_stream_if #(.LANES(LANES), .NUM_WIDTH(NW), .IMG_WIDTH(IW)) bus ();

    rescale_stream #(.LANES(LANES), .NUM_WIDTH(NW), .IMG_WIDTH(IW), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .shift     (shift),
        .round_en  (round_en),
        .sat_clear (sat_clear),
        .sat_count (sat_count),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LANES*IW-1:0] data;
        logic [LANES-1:0]    sat;
    } beat_t;

    beat_t  exp_q[$];
    longint model_cnt = 0;
    int     checks    = 0;
    int     failures  = 0;
    bit     stall_prev = 1'b0;
    logic [LANES*IW-1:0] held_data;
    logic [LANES-1:0]    held_sat;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the specification's rules.
    function automatic void ref_lane(input longint x, input int sh, input bit rnd,
                                     output logic [IW-1:0] y, output bit sat);
        int     s;
        longint t, r, hi, lo;
        s  = (sh > NW - 1) ? NW - 1 : sh;
        t  = x;
        if (rnd && s > 0) t = t + (longint'(1) << (s - 1));
        r  = t >>> s;
        hi = (longint'(1) << (IW - 1)) - 1;
        lo = -(longint'(1) << (IW - 1));
        sat = 1'b1;
        if (r > hi)      y = hi[IW-1:0];
        else if (r < lo) y = lo[IW-1:0];
        else begin
            y   = r[IW-1:0];
            sat = 1'b0;
        end
    endfunction

    function automatic beat_t model_beat(input logic [LANES*NW-1:0] d, input int sh, input bit rnd);
        beat_t b;
        for (int k = 0; k < LANES; k++) begin
            logic signed [NW-1:0] xs;
            logic [IW-1:0]        y;
            bit                   s;
            xs = d[k*NW +: NW];
            ref_lane(longint'(xs), sh, rnd, y, s);
            b.data[k*IW +: IW] = y;
            b.sat[k]           = s;
        end
        return b;
    endfunction

    function automatic logic [LANES*NW-1:0] pack(input longint l0, input longint l1,
                                                 input longint l2, input longint l3);
        logic [LANES*NW-1:0] r;
        r = '0;
        r[0*NW +: NW] = l0[NW-1:0];
        r[1*NW +: NW] = l1[NW-1:0];
        r[2*NW +: NW] = l2[NW-1:0];
        r[3*NW +: NW] = l3[NW-1:0];
        return r;
    endfunction

    function automatic longint rand_lane();
        logic [63:0]          w;
        logic signed [23:0]   m;
        logic signed [NW-1:0] f;
        w = {$urandom(), $urandom()};
        case ($urandom_range(0, 3))
            0: return longint'(int'($urandom_range(0, 2000)) - 1000);
            1: begin m = w[23:0]; return longint'(m); end
            2: begin f = w[NW-1:0]; return longint'(f); end
            default: begin
                case ($urandom_range(0, 7))
                    0: return 64'sh7FFF8;
                    1: return 64'sh7FFF7;
                    2: return -64'sh80000;
                    3: return -64'sh80008;
                    4: return 64'shFFFFFFFF;
                    5: return -64'sh100000000;
                    6: return 64'sd32767;
                    default: return -64'sd32768;
                endcase
            end
        endcase
    endfunction

    // Monitor: outputs are stable between edges, so everything is sampled at negedge.
    always @(negedge clk) begin
        bit xfer, sat_hit;
        if (rst) begin
            exp_q.delete();
            model_cnt  = 0;
            stall_prev = 1'b0;
        end else begin
            if (bus.dn_valid) begin
                if (stall_prev) begin
                    check("stall_data", bus.dn_data, held_data);
                    check("stall_sat", bus.dn_sat, held_sat);
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got data 0x%0h with no beat expected at %0t",
                             bus.dn_data, $time);
                end else begin
                    check("dn_data", bus.dn_data, exp_q[0].data);
                    check("dn_sat", bus.dn_sat, exp_q[0].sat);
                end
            end
            check("sat_count", sat_count, model_cnt[CW-1:0]);
            xfer       = bus.dn_valid && bus.dn_ready;
            stall_prev = bus.dn_valid && !bus.dn_ready;
            held_data  = bus.dn_data;
            held_sat   = bus.dn_sat;
            sat_hit    = xfer && (exp_q.size() > 0) && (|exp_q[0].sat);
            if (xfer && exp_q.size() > 0) void'(exp_q.pop_front());
            if (sat_clear) model_cnt = 0;
            else if (sat_hit && model_cnt != CMAX) model_cnt++;
            if (bus.up_valid && bus.up_ready)
                exp_q.push_back(model_beat(bus.up_data, int'(shift), round_en));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [LANES*NW-1:0] d, input logic [7:0] sh, input bit rnd);
        bit acc;
        int n;
        n = 0;
        bus.up_data  = d;
        shift        = sh;
        round_en     = rnd;
        bus.up_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = bus.up_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 500);
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got no up_ready in %0d cycles, required acceptance", n);
        end
        bus.up_valid = 1'b0;
        shift        = 8'($urandom());
        round_en     = 1'($urandom());
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.dn_valid) && n < 500) begin
            tick();
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    // One beat into an empty pipeline; dn_valid must appear on the third edge.
    task automatic latency_test();
        send(pack(64'sh12345, -64'sd32, 0, 1), 8'd4, 1'b0);
        check("lat_cycle1", bus.dn_valid, 1'b0);
        tick();
        check("lat_cycle2", bus.dn_valid, 1'b0);
        tick();
        check("lat_cycle3", bus.dn_valid, 1'b1);
        check("lat_lane0", bus.dn_data[15:0], 16'h1234);
        check("lat_lane1", bus.dn_data[31:16], 16'hFFFE);
        check("lat_sat", bus.dn_sat, 4'b0000);
        drain();
    endtask

    task automatic summary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        #3_000_000;
        checks++;
        failures++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        summary();
        $finish;
    end

    initial begin
        logic [IW-1:0] y;
        bit            s;
        bit            prod_done;

        rst          = 1'b1;
        shift        = '0;
        round_en     = 1'b0;
        sat_clear    = 1'b0;
        bus.up_data  = '0;
        bus.up_valid = 1'b0;
        bus.dn_ready = 1'b0;

        // Reset state
        tick();
        check("rst_dn_valid", bus.dn_valid, 1'b0);
        check("rst_dn_data", bus.dn_data, '0);
        check("rst_dn_sat", bus.dn_sat, '0);
        check("rst_sat_count", sat_count, '0);
        check("rst_up_ready", bus.up_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Pin the model to hand-computed values
        ref_lane(64'sh12345, 4, 1'b0, y, s);     check("ref_trunc", {s, y}, {1'b0, 16'h1234});
        ref_lane(-64'sd32, 4, 1'b0, y, s);       check("ref_neg", {s, y}, {1'b0, 16'hFFFE});
        ref_lane(64'sd24, 4, 1'b1, y, s);        check("ref_round_up", {s, y}, {1'b0, 16'h0002});
        ref_lane(64'sd24, 4, 1'b0, y, s);        check("ref_round_off", {s, y}, {1'b0, 16'h0001});
        ref_lane(-64'sd24, 4, 1'b1, y, s);       check("ref_round_neg", {s, y}, {1'b0, 16'hFFFF});
        ref_lane(64'sh100000, 4, 1'b0, y, s);    check("ref_sat_hi", {s, y}, {1'b1, 16'h7FFF});
        ref_lane(-64'sh100000, 4, 1'b0, y, s);   check("ref_sat_lo", {s, y}, {1'b1, 16'h8000});
        ref_lane(64'sh7FFF8, 4, 1'b1, y, s);     check("ref_round_sat", {s, y}, {1'b1, 16'h7FFF});
        ref_lane(64'sh100000, 200, 1'b0, y, s);  check("ref_big_shift", {s, y}, {1'b0, 16'h0000});

        bus.dn_ready = 1'b1;
        latency_test();

        // Directed rounding / saturation beats through the scoreboard
        send(pack(24, -24, 24, 1234), 8'd4, 1'b1);
        send(pack(24, -24, 7, -7), 8'd4, 1'b0);
        send(pack(1234, -1234, 32767, -32768), 8'd0, 1'b1);
        send(pack(64'sh100000, -64'sh100000, 64'sh7FFF8, -64'sh80008), 8'd4, 1'b1);
        send(pack(64'sh100000, -64'sh100000, 64'shFFFFFFFF, -64'sh100000000), 8'd200, 1'b0);
        send(pack(64'shFFFFFFFF, -64'sh100000000, 5, -5), 8'd32, 1'b1);
        send(pack(64'shFFFFFFFF, -64'sh100000000, 64'sh1FFFF, 3), 8'd17, 1'b1);
        drain();

        // Backpressure: 10 incrementing beats, 5-cycle downstream stall mid-stream
        prod_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(pack(1000 * (i + 1), -100 * i, 64'sh10000 + i, i), 8'(i % 6), 1'(i % 2));
                prod_done = 1'b1;
            end
            begin
                tick(); tick(); tick();
                bus.dn_ready = 1'b0;
                repeat (5) tick();
                check("bp_up_ready_low", bus.up_ready, 1'b0);
                check("bp_dn_valid_held", bus.dn_valid, 1'b1);
                bus.dn_ready = 1'b1;
            end
        join
        drain();

        // Counter: count of 5, clear priority, hold at all-ones
        sat_clear = 1'b1;
        tick();
        sat_clear = 1'b0;
        for (int i = 0; i < 5; i++) send(pack(64'sh100000, 0, 0, 0), 8'd4, 1'b0);
        drain();
        check("cnt_five", sat_count, 16'd5);
        send(pack(-64'sh100000, 0, 0, 0), 8'd4, 1'b0);
        tick();
        tick();
        check("clr_beat_valid", bus.dn_valid, 1'b1);
        sat_clear = 1'b1;
        tick();
        sat_clear = 1'b0;
        check("cnt_clear_priority", sat_count, 16'd0);
        for (int i = 0; i < 65540; i++) send(pack(0, 64'sh7FFF8, 0, 0), 8'd4, 1'b1);
        drain();
        check("cnt_hold_max", sat_count, 16'hFFFF);

        // Randomised traffic with random backpressure and occasional clears
        prod_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 600; i++) begin
                    logic [7:0] sh;
                    repeat ($urandom_range(0, 2)) tick();
                    if ($urandom_range(0, 40) == 0) begin
                        sat_clear = 1'b1;
                        tick();
                        sat_clear = 1'b0;
                    end
                    case ($urandom_range(0, 5))
                        0:       sh = 8'($urandom_range(200, 255));
                        1:       sh = 8'($urandom_range(21, 40));
                        default: sh = 8'($urandom_range(0, 20));
                    endcase
                    send(pack(rand_lane(), rand_lane(), rand_lane(), rand_lane()), sh, 1'($urandom()));
                end
                prod_done = 1'b1;
            end
            begin
                while (!prod_done) begin
                    bus.dn_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
                bus.dn_ready = 1'b1;
            end
        join
        drain();

        // Reset with every stage full
        send(pack(64'sh100000, 0, 0, 0), 8'd4, 1'b0);
        send(pack(64'sh100000, 0, 0, 0), 8'd4, 1'b0);
        drain();
        bus.dn_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(pack(64'sh100000, 77, -77, i), 8'd4, 1'b0);
        check("full_up_ready", bus.up_ready, 1'b0);
        check("full_sat_nonzero", (sat_count != '0), 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_dn_valid", bus.dn_valid, 1'b0);
        check("mid_rst_sat_count", sat_count, '0);
        check("mid_rst_dn_sat", bus.dn_sat, '0);
        check("mid_rst_dn_data", bus.dn_data, '0);
        check("mid_rst_up_ready", bus.up_ready, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        bus.dn_ready = 1'b1;
        tick();
        latency_test();

        summary();
        $finish;
    end
endmodule

// File: doc/rescale_stream.md
Name: rescale_stream

Overview:
- Multi-lane, flow-controlled successor to the single-lane MAC/ADD rescaler.
- Takes LANES signed NUM_WIDTH accumulator words per beat and arithmetically right-shifts each by a per-beat shift. Optional round-half-up, then exact saturation to signed IMG_WIDTH.
- Sits between the filter accumulator array and the image output stream. Adds a valid/ready handshake, per-lane saturation flags and a saturation event counter.

Parameters:
- LANES, 4, number of independent lanes per beat
- NUM_WIDTH, 33, signed accumulator width per lane
- IMG_WIDTH, 16, signed output pixel width per lane (IMG_WIDTH < NUM_WIDTH)
- CNT_WIDTH, 16, width of saturation event counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- shift  in  8  right-shift amount, sampled with each accepted beat
- round_en  in  1  1 = round-half-up, 0 = truncate; sampled with each accepted beat
- up_data  in  LANES*NUM_WIDTH  lane k at [k*NUM_WIDTH +: NUM_WIDTH], two's complement
- up_valid  in  1  upstream beat valid
- up_ready  out  1  block can accept a beat
- dn_data  out  LANES*IMG_WIDTH  lane k at [k*IMG_WIDTH +: IMG_WIDTH]
- dn_sat  out  LANES  per-lane flag: this lane was clamped
- dn_valid  out  1  output beat valid
- dn_ready  in  1  downstream accepts beat
- sat_clear  in  1  synchronous clear of sat_count
- sat_count  out  CNT_WIDTH  count of output beats with any dn_sat bit set

Behaviour:
- Reset: async, active-high. All stage valids, dn_valid, dn_data, dn_sat and sat_count go to 0 immediately. up_ready is 1 after reset.
- Pipeline has 3 registered stages:
  - S1 captures up_data, shift and round_en on each up_valid && up_ready.
  - S2 computes rounded, shifted value per lane.
  - S3 clamps the value and holds the dn_* registers.
- Latency is 3 cycles from acceptance to dn_valid with no backpressure. Throughput is 1 beat/cycle.
- Flow control: stage k advances when ~valid_k | ready_(k+1). S3 advances when ~dn_valid | dn_ready, so up_ready = ~v1 | ~v2 | ~v3 | dn_ready (combinational).
  - Bubbles collapse.
  - Stalled stages hold data and config unchanged.
  - No beat is lost or duplicated, and order is preserved.
- dn_data and dn_sat are stable while dn_valid && ~dn_ready.
- shift and round_en travel with their beat. Changing these inputs mid-stream never affects beats already accepted.
- Effective shift s = min(shift, NUM_WIDTH-1).
- Arithmetic (per lane, signed, NUM_WIDTH+1 bits to avoid overflow):
  - If round_en and s > 0: t = x + 2^(s-1). Otherwise t = x.
  - r = t >>> s (arithmetic shift).
- Saturation:
  - If r > 2^(IMG_WIDTH-1)-1: lane output is IMG_MAX (0x7FFF for 16-bit) and dn_sat[k] = 1.
  - If r < -2^(IMG_WIDTH-1): lane output is IMG_MIN (0x8000) and dn_sat[k] = 1.
  - Otherwise lane output is r[IMG_WIDTH-1:0] and dn_sat[k] = 0.
- Rounding can cause overflow (e.g. rounding up past IMG_MAX). Overflow from rounding saturates as above.
- sat_count:
  - Increments by 1 on each dn_valid && dn_ready transfer with |dn_sat.
  - Holds at all-ones and does not wrap.
  - sat_clear has priority: if sat_clear coincides with a counted transfer, the result is 0.

Test Plan:
- Truncate, NUM_WIDTH=33, IMG_WIDTH=16, LANES=2, shift=4, round_en=0: lane0=0x12345, lane1=-32 → dn_data lanes 0x1234 / 0xFFFE, dn_sat=00, dn_valid exactly 3 cycles after acceptance.
- Rounding, shift=4: 24 with round_en=1 → 0x0002, with round_en=0 → 0x0001; -24 with round_en=1 → 0xFFFF; shift=0 with round_en=1 → value passes unchanged.
- Saturation, shift=4: 0x100000 → 0x7FFF with dn_sat=1; -0x100000 → 0x8000 with dn_sat=1; 0x7FFF8 with round_en=1 → 0x7FFF with dn_sat=1; shift=200 → clamped to 32, 0x100000 → 0x0000.
- Backpressure: stream 10 beats with incrementing data and varying shift; hold dn_ready=0 for 5 cycles mid-stream → up_ready drops once 3 beats are held, dn_data stable while stalled, all 10 beats delivered in order with correct per-beat shift.
- Counter: 5 saturating beats → sat_count=5. sat_clear asserted on a saturating transfer → 0. Preload via 2^CNT_WIDTH+2 saturating beats (or force) → sat_count holds 0xFFFF.
- Reset mid-stream: assert rst with all stages valid → dn_valid=0 and sat_count=0 immediately. After release, first new beat emerges 3 cycles after acceptance with no stale data.
